// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order retire of up to two entries per cycle.
// Entries are allocated at issue, and results arrive on NUM_WB writeback ports.
// Retire drives the regfile, the store path (one outstanding store), the
// branch predictor update, and a mispredict flush/redirect.
// Optional feature macro: ROB_DUAL_COMMIT_EN enables the second retire lane.
// Opcode encoding follows the shared defines: JALR=4, BEQ..BGEU=5..10, SB..SW=16..18.
module rob_multi_commit #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned NUM_WB = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rdy_i,
  // issue
  input  logic                     issue_valid_i,
  input  logic [5:0]               issue_op_i,
  input  logic [5:0]               issue_rd_i,
  input  logic [31:0]              issue_pc_i,
  input  logic [31:0]              issue_pred_pc_i,
  output logic [IDX_W-1:0]         issue_entry_o,
  output logic                     rob_full_o,
  // writeback
  input  logic [NUM_WB-1:0]        wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0]  wb_entry_i,
  input  logic [NUM_WB*32-1:0]     wb_value_i,
  input  logic [NUM_WB*32-1:0]     wb_addr_i,
  input  logic [NUM_WB*32-1:0]     wb_real_pc_i,
  // store path
  output logic                     st_req_o,
  output logic [5:0]               st_op_o,
  output logic [31:0]              st_addr_o,
  output logic [31:0]              st_data_o,
  input  logic                     st_done_i,
  // retire lanes
  output logic                     cm0_valid_o,
  output logic [IDX_W-1:0]         cm0_entry_o,
  output logic [5:0]               cm0_rd_o,
  output logic [31:0]              cm0_value_o,
  output logic                     cm1_valid_o,
  output logic [IDX_W-1:0]         cm1_entry_o,
  output logic [5:0]               cm1_rd_o,
  output logic [31:0]              cm1_value_o,
  // predictor update and flush
  output logic                     br_valid_o,
  output logic [31:0]              br_pc_o,
  output logic                     br_taken_o,
  output logic                     flush_o,
  output logic [31:0]              redirect_pc_o
);

  localparam int unsigned CntW = IDX_W + 1;
  localparam logic [IDX_W-1:0] IdxOne = 1;

  localparam logic [5:0] OpJalr = 6'd4;
  localparam logic [5:0] OpBeq  = 6'd5;
  localparam logic [5:0] OpBgeu = 6'd10;
  localparam logic [5:0] OpSb   = 6'd16;
  localparam logic [5:0] OpSw   = 6'd18;

  typedef enum logic [0:0] {StIdle, StStoreWait} state_e;

  function automatic logic is_store(input logic [5:0] op);
    return (op >= OpSb) && (op <= OpSw);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OpBeq) && (op <= OpBgeu);
  endfunction

  // Entry storage; only the ready bits need a reset value.
  logic [5:0]  op_q      [DEPTH];
  logic [5:0]  rd_q      [DEPTH];
  logic [31:0] pc_q      [DEPTH];
  logic [31:0] pred_q    [DEPTH];
  logic [31:0] value_q   [DEPTH];
  logic [31:0] addr_q    [DEPTH];
  logic [31:0] real_pc_q [DEPTH];
  logic [DEPTH-1:0] ready_q, ready_d;

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  state_e           state_q, state_d;

  logic [IDX_W-1:0] wb_tag [NUM_WB];

  logic        full, head_rdy, head_mispred;
  logic [5:0]  head_op;
  logic        lane0_go, lane1_go, store_start, store_done, flush_go;
  logic        accept_ok, issue_accept;
  logic [1:0]  n_ret;

  // Output registers
  logic             cm0_valid_q;
  logic [IDX_W-1:0] cm0_entry_q;
  logic [5:0]       cm0_rd_q;
  logic [31:0]      cm0_value_q;
  logic             br_valid_q, br_taken_q, flush_q;
  logic [31:0]      br_pc_q, redirect_pc_q;
  logic             st_req_q;
  logic [5:0]       st_op_q;
  logic [31:0]      st_addr_q, st_data_q;

  // Unpack writeback tags per port.
  always_comb begin
    for (int p = 0; p < int'(NUM_WB); p++) begin
      wb_tag[p] = wb_entry_i[p*IDX_W +: IDX_W];
    end
  end

  // Retire/issue decisions for this cycle.
  always_comb begin
    full         = (count_q == CntW'(DEPTH));
    head_op      = op_q[head_q];
    head_rdy     = (count_q != '0) && ready_q[head_q];
    head_mispred = (is_branch(head_op) || (head_op == OpJalr)) &&
                   (real_pc_q[head_q] != pred_q[head_q]);
    lane0_go     = rdy_i && (state_q == StIdle) && head_rdy && !is_store(head_op);
    store_start  = rdy_i && (state_q == StIdle) && head_rdy && is_store(head_op);
    store_done   = rdy_i && (state_q == StStoreWait) && st_done_i;
    flush_go     = lane0_go && head_mispred;
    // Issue and writeback are wrong-path on the flush edge and while flush is visible.
    accept_ok    = rdy_i && !flush_go && !flush_q;
    issue_accept = accept_ok && issue_valid_i && !full;
  end

`ifdef ROB_DUAL_COMMIT_EN
  logic [IDX_W-1:0] head1;
  logic [5:0]       op1;

  // Second lane: only plain ops directly behind a cleanly retiring head.
  always_comb begin
    head1    = head_q + IdxOne;
    op1      = op_q[head1];
    lane1_go = lane0_go && !head_mispred && (count_q >= CntW'(2)) && ready_q[head1] &&
               !is_store(op1) && !is_branch(op1) && (op1 != OpJalr);
  end

  logic             cm1_valid_q;
  logic [IDX_W-1:0] cm1_entry_q;
  logic [5:0]       cm1_rd_q;
  logic [31:0]      cm1_value_q;

  // Lane 1 retire pulse and data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cm1_valid_q <= 1'b0;
      cm1_entry_q <= '0;
      cm1_rd_q    <= '0;
      cm1_value_q <= '0;
    end else if (!rdy_i) begin
      cm1_valid_q <= 1'b0;
    end else begin
      cm1_valid_q <= lane1_go;
      cm1_entry_q <= lane1_go ? head1 : '0;
      cm1_rd_q    <= lane1_go ? rd_q[head1] : '0;
      cm1_value_q <= lane1_go ? value_q[head1] : '0;
    end
  end

  assign cm1_valid_o = cm1_valid_q & rdy_i;
  assign cm1_entry_o = cm1_entry_q;
  assign cm1_rd_o    = cm1_rd_q;
  assign cm1_value_o = cm1_value_q;
`else
  assign lane1_go    = 1'b0;
  assign cm1_valid_o = 1'b0;
  assign cm1_entry_o = '0;
  assign cm1_rd_o    = '0;
  assign cm1_value_o = '0;
`endif

  // Pointer, occupancy and ready-bit next state.
  always_comb begin
    n_ret   = {1'b0, lane0_go} + {1'b0, lane1_go} + {1'b0, store_done};
    head_d  = head_q + IDX_W'(n_ret);
    tail_d  = tail_q + IDX_W'(issue_accept);
    count_d = count_q + CntW'(issue_accept) - CntW'(n_ret);
    ready_d = ready_q;
    if (lane0_go || store_done) ready_d[head_q] = 1'b0;
    if (lane1_go) ready_d[head_q + IdxOne] = 1'b0;
    if (accept_ok) begin
      for (int p = 0; p < int'(NUM_WB); p++) begin
        if (wb_valid_i[p]) ready_d[wb_tag[p]] = 1'b1;
      end
    end
    if (issue_accept) ready_d[tail_q] = 1'b0;
    if (flush_go) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = '0;
    end
  end

  // Store-wait FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (store_start) state_d = StStoreWait;
      StStoreWait: if (store_done) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Control state registers; rdy low freezes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= '0;
      state_q <= StIdle;
    end else if (rdy_i) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
      state_q <= state_d;
    end
  end

  // Entry payload; ports are walked high to low so the lowest index wins a tag clash.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept_ok) begin
      for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
        if (wb_valid_i[p]) begin
          value_q[wb_tag[p]]   <= wb_value_i[p*32 +: 32];
          addr_q[wb_tag[p]]    <= wb_addr_i[p*32 +: 32];
          real_pc_q[wb_tag[p]] <= wb_real_pc_i[p*32 +: 32];
        end
      end
      if (issue_accept) begin
        op_q[tail_q]   <= issue_op_i;
        rd_q[tail_q]   <= issue_rd_i;
        pc_q[tail_q]   <= issue_pc_i;
        pred_q[tail_q] <= issue_pred_pc_i;
      end
    end
  end

  // Lane 0 retire, predictor update and flush pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cm0_valid_q   <= 1'b0;
      cm0_entry_q   <= '0;
      cm0_rd_q      <= '0;
      cm0_value_q   <= '0;
      br_valid_q    <= 1'b0;
      br_pc_q       <= '0;
      br_taken_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else if (!rdy_i) begin
      cm0_valid_q <= 1'b0;
      br_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      cm0_valid_q   <= lane0_go || store_done;
      cm0_entry_q   <= (lane0_go || store_done) ? head_q : '0;
      cm0_rd_q      <= lane0_go ? rd_q[head_q] : '0;
      cm0_value_q   <= (lane0_go || store_done) ? value_q[head_q] : '0;
      br_valid_q    <= lane0_go && is_branch(head_op);
      br_pc_q       <= (lane0_go && is_branch(head_op)) ? pc_q[head_q] : '0;
      br_taken_q    <= lane0_go && is_branch(head_op) &&
                       (real_pc_q[head_q] != pc_q[head_q] + 32'd4);
      flush_q       <= flush_go;
      redirect_pc_q <= flush_go ? real_pc_q[head_q] : '0;
    end
  end

  // Store request: raised when a ready store reaches head, held until st_done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_req_q  <= 1'b0;
      st_op_q   <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
    end else if (store_start) begin
      st_req_q  <= 1'b1;
      st_op_q   <= head_op;
      st_addr_q <= addr_q[head_q];
      st_data_q <= value_q[head_q];
    end else if (store_done) begin
      st_req_q <= 1'b0;
    end
  end

  assign issue_entry_o = tail_q;
  assign rob_full_o    = full;
  assign st_req_o      = st_req_q;
  assign st_op_o       = st_op_q;
  assign st_addr_o     = st_addr_q;
  assign st_data_o     = st_data_q;
  assign cm0_valid_o   = cm0_valid_q & rdy_i;
  assign cm0_entry_o   = cm0_entry_q;
  assign cm0_rd_o      = cm0_rd_q;
  assign cm0_value_o   = cm0_value_q;
  assign br_valid_o    = br_valid_q & rdy_i;
  assign br_pc_o       = br_pc_q;
  assign br_taken_o    = br_taken_q;
  assign flush_o       = flush_q & rdy_i;
  assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit; expectations follow ROB_DUAL_COMMIT_EN if defined.
module tb_rob_multi_commit;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned NUM_WB = 3;

  localparam logic [5:0] OpJalr = 6'd4;
  localparam logic [5:0] OpBeq  = 6'd5;
  localparam logic [5:0] OpSw   = 6'd18;
  localparam logic [5:0] OpAdd  = 6'd28;

  logic clk = 1'b0;
  logic rst, rdy;
  logic issue_valid;
  logic [5:0] issue_op, issue_rd;
  logic [31:0] issue_pc, issue_pred_pc;
  logic [IDX_W-1:0] issue_entry;
  logic rob_full;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_entry;
  logic [NUM_WB*32-1:0] wb_value, wb_addr, wb_real_pc;
  logic st_req, st_done;
  logic [5:0] st_op;
  logic [31:0] st_addr, st_data;
  logic cm0_valid, cm1_valid;
  logic [IDX_W-1:0] cm0_entry, cm1_entry;
  logic [5:0] cm0_rd, cm1_rd;
  logic [31:0] cm0_value, cm1_value;
  logic br_valid, br_taken, flush;
  logic [31:0] br_pc, redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_multi_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
    .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
    .issue_valid_i(issue_valid), .issue_op_i(issue_op), .issue_rd_i(issue_rd),
    .issue_pc_i(issue_pc), .issue_pred_pc_i(issue_pred_pc),
    .issue_entry_o(issue_entry), .rob_full_o(rob_full),
    .wb_valid_i(wb_valid), .wb_entry_i(wb_entry), .wb_value_i(wb_value),
    .wb_addr_i(wb_addr), .wb_real_pc_i(wb_real_pc),
    .st_req_o(st_req), .st_op_o(st_op), .st_addr_o(st_addr), .st_data_o(st_data),
    .st_done_i(st_done),
    .cm0_valid_o(cm0_valid), .cm0_entry_o(cm0_entry), .cm0_rd_o(cm0_rd),
    .cm0_value_o(cm0_value),
    .cm1_valid_o(cm1_valid), .cm1_entry_o(cm1_entry), .cm1_rd_o(cm1_rd),
    .cm1_value_o(cm1_value),
    .br_valid_o(br_valid), .br_pc_o(br_pc), .br_taken_o(br_taken),
    .flush_o(flush), .redirect_pc_o(redirect_pc)
  );

  initial begin
    #100000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wb();
    wb_valid = '0; wb_entry = '0; wb_value = '0; wb_addr = '0; wb_real_pc = '0;
  endtask

  task automatic set_wb(input int p, input logic [IDX_W-1:0] tag, input logic [31:0] val,
                        input logic [31:0] addr, input logic [31:0] rpc);
    wb_valid[p] = 1'b1;
    wb_entry[p*IDX_W +: IDX_W] = tag;
    wb_value[p*32 +: 32] = val;
    wb_addr[p*32 +: 32] = addr;
    wb_real_pc[p*32 +: 32] = rpc;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [5:0] rd,
                             input logic [31:0] pc, input logic [31:0] pred);
    issue_valid = 1'b1; issue_op = op; issue_rd = rd; issue_pc = pc; issue_pred_pc = pred;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_rd = '0;
    issue_pc = '0; issue_pred_pc = '0; st_done = 1'b0;
    clr_wb();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (issue_entry !== 5'd0) begin errors++;
      $display("FAIL rst_issue_entry got %0d exp 0", issue_entry); end
    checks++; if (rob_full !== 1'b0) begin errors++;
      $display("FAIL rst_rob_full got %0b exp 0", rob_full); end
    checks++; if (st_req !== 1'b0) begin errors++;
      $display("FAIL rst_st_req got %0b exp 0", st_req); end
    checks++; if ({cm0_valid, cm1_valid, br_valid, flush} !== 4'b0) begin errors++;
      $display("FAIL rst_pulses got %b exp 0000", {cm0_valid, cm1_valid, br_valid, flush}); end
    checks++; if (redirect_pc !== 32'd0) begin errors++;
      $display("FAIL rst_redirect got %h exp 0", redirect_pc); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      drive_issue(OpAdd, 6'd1, 32'(i * 4), 32'(i * 4 + 4));
      if (i == 30) begin
        checks++; if (issue_entry !== 5'd31) begin errors++;
          $display("FAIL fill_entry31 got %0d exp 31", issue_entry); end
        checks++; if (rob_full !== 1'b0) begin errors++;
          $display("FAIL fill_notfull got %0b exp 0", rob_full); end
      end
    end
    checks++; if (rob_full !== 1'b1) begin errors++;
      $display("FAIL fill_full got %0b exp 1", rob_full); end
    checks++; if (issue_entry !== 5'd0) begin errors++;
      $display("FAIL fill_wrap got %0d exp 0", issue_entry); end
    drive_issue(OpAdd, 6'd1, 32'h200, 32'h204);
    checks++; if (rob_full !== 1'b1 || issue_entry !== 5'd0) begin errors++;
      $display("FAIL fill_33rd got full=%0b entry=%0d exp full=1 entry=0", rob_full, issue_entry);
    end
    checks++; if (cm0_valid !== 1'b0) begin errors++;
      $display("FAIL fill_noretire got %0b exp 0", cm0_valid); end
  endtask

  task automatic test_out_of_order_wb();
    apply_reset();
    drive_issue(OpAdd, 6'd3, 32'h0, 32'h4);
    drive_issue(OpAdd, 6'd4, 32'h4, 32'h8);
    set_wb(0, 5'd1, 32'h11, 32'h0, 32'h8);
    tick();
    clr_wb();
    checks++; if (cm0_valid !== 1'b0) begin errors++;
      $display("FAIL ooo_wait1 got %0b exp 0", cm0_valid); end
    set_wb(0, 5'd0, 32'h10, 32'h0, 32'h4);
    tick();
    clr_wb();
    checks++; if (cm0_valid !== 1'b0) begin errors++;
      $display("FAIL ooo_wait2 got %0b exp 0", cm0_valid); end
    tick();
    checks++; if (cm0_valid !== 1'b1 || cm0_entry !== 5'd0 || cm0_rd !== 6'd3 ||
                  cm0_value !== 32'h10) begin errors++;
      $display("FAIL ooo_cm0 got v=%0b e=%0d rd=%0d val=%h exp v=1 e=0 rd=3 val=10",
               cm0_valid, cm0_entry, cm0_rd, cm0_value); end
`ifdef ROB_DUAL_COMMIT_EN
    checks++; if (cm1_valid !== 1'b1 || cm1_entry !== 5'd1 || cm1_rd !== 6'd4 ||
                  cm1_value !== 32'h11) begin errors++;
      $display("FAIL ooo_cm1 got v=%0b e=%0d rd=%0d val=%h exp v=1 e=1 rd=4 val=11",
               cm1_valid, cm1_entry, cm1_rd, cm1_value); end
    tick();
    checks++; if (cm0_valid !== 1'b0) begin errors++;
      $display("FAIL ooo_drained got %0b exp 0", cm0_valid); end
`else
    checks++; if (cm1_valid !== 1'b0) begin errors++;
      $display("FAIL ooo_cm1_off got %0b exp 0", cm1_valid); end
    tick();
    checks++; if (cm0_valid !== 1'b1 || cm0_entry !== 5'd1 || cm0_value !== 32'h11) begin
      errors++;
      $display("FAIL ooo_cm0_second got v=%0b e=%0d val=%h exp v=1 e=1 val=11",
               cm0_valid, cm0_entry, cm0_value); end
`endif
  endtask

  task automatic test_store();
    apply_reset();
    drive_issue(OpSw, 6'd0, 32'h10, 32'h14);
    drive_issue(OpAdd, 6'd5, 32'h14, 32'h18);
    set_wb(2, 5'd0, 32'hDEAD, 32'h100, 32'h14);
    tick();
    clr_wb();
    set_wb(0, 5'd1, 32'h55, 32'h0, 32'h18);
    tick();
    clr_wb();
    checks++; if (st_op !== OpSw || st_addr !== 32'h100 || st_data !== 32'hDEAD) begin errors++;
      $display("FAIL st_desc got op=%0d addr=%h data=%h exp op=18 addr=100 data=dead",
               st_op, st_addr, st_data); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (st_req !== 1'b1 || cm0_valid !== 1'b0) begin errors++;
        $display("FAIL st_hold%0d got req=%0b cm0=%0b exp req=1 cm0=0", i, st_req, cm0_valid);
      end
      if (i < 3) tick();
    end
    st_done = 1'b1;
    tick();
    st_done = 1'b0;
    checks++; if (st_req !== 1'b0 || cm0_valid !== 1'b1 || cm0_entry !== 5'd0 ||
                  cm0_rd !== 6'd0) begin errors++;
      $display("FAIL st_done got req=%0b cm0=%0b e=%0d rd=%0d exp req=0 cm0=1 e=0 rd=0",
               st_req, cm0_valid, cm0_entry, cm0_rd); end
    tick();
    checks++; if (cm0_valid !== 1'b1 || cm0_entry !== 5'd1 || cm0_rd !== 6'd5 ||
                  cm0_value !== 32'h55) begin errors++;
      $display("FAIL st_younger got v=%0b e=%0d rd=%0d val=%h exp v=1 e=1 rd=5 val=55",
               cm0_valid, cm0_entry, cm0_rd, cm0_value); end
  endtask

  task automatic test_mispredict();
    apply_reset();
    drive_issue(OpBeq, 6'd0, 32'h40, 32'h44);
    for (int i = 1; i < 4; i++) drive_issue(OpAdd, 6'(i), 32'(32'h40 + i * 4), 32'(32'h44 + i * 4));
    set_wb(0, 5'd1, 32'h1, 32'h0, 32'h48);
    tick();
    clr_wb();
    set_wb(0, 5'd2, 32'h2, 32'h0, 32'h4C);
    set_wb(1, 5'd3, 32'h3, 32'h0, 32'h50);
    tick();
    clr_wb();
    checks++; if (cm0_valid !== 1'b0) begin errors++;
      $display("FAIL mp_blocked got %0b exp 0", cm0_valid); end
    set_wb(0, 5'd0, 32'h0, 32'h0, 32'h80);
    tick();
    clr_wb();
    issue_valid = 1'b1; issue_op = OpAdd; issue_rd = 6'd9; issue_pc = 32'h44;
    issue_pred_pc = 32'h48;
    tick();
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h80) begin errors++;
      $display("FAIL mp_flush got flush=%0b pc=%h exp flush=1 pc=80", flush, redirect_pc); end
    checks++; if (br_valid !== 1'b1 || br_pc !== 32'h40 || br_taken !== 1'b1) begin errors++;
      $display("FAIL mp_br got v=%0b pc=%h tk=%0b exp v=1 pc=40 tk=1", br_valid, br_pc,
               br_taken); end
    checks++; if (cm0_valid !== 1'b1 || cm0_entry !== 5'd0 || cm1_valid !== 1'b0) begin
      errors++;
      $display("FAIL mp_retire got cm0=%0b e=%0d cm1=%0b exp cm0=1 e=0 cm1=0",
               cm0_valid, cm0_entry, cm1_valid); end
    checks++; if (issue_entry !== 5'd0) begin errors++;
      $display("FAIL mp_tail got %0d exp 0", issue_entry); end
    tick();
    issue_valid = 1'b0;
    checks++; if (issue_entry !== 5'd0 || flush !== 1'b0 || cm0_valid !== 1'b0) begin errors++;
      $display("FAIL mp_after got entry=%0d flush=%0b cm0=%0b exp 0 0 0",
               issue_entry, flush, cm0_valid); end
    tick();
    tick();
    checks++; if (cm0_valid !== 1'b0 || rob_full !== 1'b0) begin errors++;
      $display("FAIL mp_empty got cm0=%0b full=%0b exp 0 0", cm0_valid, rob_full); end
  endtask

  task automatic test_jalr_and_wb_priority();
    apply_reset();
    drive_issue(OpJalr, 6'd1, 32'h100, 32'h200);
    drive_issue(OpAdd, 6'd7, 32'h200, 32'h204);
    set_wb(0, 5'd0, 32'h104, 32'h0, 32'h200);
    tick();
    clr_wb();
    set_wb(0, 5'd1, 32'hAAAA, 32'h0, 32'h204);
    set_wb(1, 5'd1, 32'hBBBB, 32'h0, 32'h204);
    tick();
    clr_wb();
    checks++; if (cm0_valid !== 1'b1 || cm0_entry !== 5'd0 || cm0_value !== 32'h104) begin
      errors++;
      $display("FAIL jalr_retire got v=%0b e=%0d val=%h exp v=1 e=0 val=104",
               cm0_valid, cm0_entry, cm0_value); end
    checks++; if (flush !== 1'b0 || br_valid !== 1'b0) begin errors++;
      $display("FAIL jalr_noflush got flush=%0b br=%0b exp 0 0", flush, br_valid); end
    tick();
    checks++; if (cm0_valid !== 1'b1 || cm0_entry !== 5'd1 || cm0_value !== 32'hAAAA) begin
      errors++;
      $display("FAIL wb_prio got v=%0b e=%0d val=%h exp v=1 e=1 val=aaaa",
               cm0_valid, cm0_entry, cm0_value); end
  endtask

  task automatic test_reset_mid_store();
    apply_reset();
    drive_issue(OpSw, 6'd0, 32'h20, 32'h24);
    set_wb(2, 5'd0, 32'h1234, 32'h300, 32'h24);
    tick();
    clr_wb();
    tick();
    checks++; if (st_req !== 1'b1) begin errors++;
      $display("FAIL rs_req_up got %0b exp 1", st_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (st_req !== 1'b0 || st_addr !== 32'd0 || st_data !== 32'd0) begin errors++;
      $display("FAIL rs_req_drop got req=%0b addr=%h data=%h exp 0 0 0", st_req, st_addr,
               st_data); end
    checks++; if (issue_entry !== 5'd0 || cm0_valid !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL rs_state got entry=%0d cm0=%0b flush=%0b exp 0 0 0", issue_entry,
               cm0_valid, flush); end
    st_done = 1'b1;
    tick();
    st_done = 1'b0;
    tick();
    checks++; if (cm0_valid !== 1'b0 || st_req !== 1'b0) begin errors++;
      $display("FAIL rs_abandoned got cm0=%0b req=%0b exp 0 0", cm0_valid, st_req); end
  endtask

  task automatic test_rdy_freeze();
    apply_reset();
    rdy = 1'b0;
    drive_issue(OpAdd, 6'd2, 32'h0, 32'h4);
    checks++; if (issue_entry !== 5'd0) begin errors++;
      $display("FAIL rdy_frozen got %0d exp 0", issue_entry); end
    rdy = 1'b1;
    drive_issue(OpAdd, 6'd2, 32'h0, 32'h4);
    checks++; if (issue_entry !== 5'd1) begin errors++;
      $display("FAIL rdy_resume got %0d exp 1", issue_entry); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_out_of_order_wb();
    test_store();
    test_mispredict();
    test_jalr_and_wb_priority();
    test_reset_mid_store();
    test_rdy_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
